// File: rtl/mod_counter_pkg.sv
// Shared constants, FSM state type and helpers for the mod-38 counter load controller.
package mod_counter_pkg;

  localparam int unsigned W   = 6;
  localparam int unsigned MOD = 38;
  localparam int unsigned IdW = 3;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCheck,
    StGuard
  } state_e;

  // Round-robin successor of a grant index, wrapping at n requesters.
  function automatic logic [IdW-1:0] rr_next(input logic [IdW-1:0] g, input int unsigned n);
    if (32'(g) + 32'd1 >= n) begin
      return '0;
    end
    return g + 3'd1;
  endfunction

endpackage

// File: rtl/mod_counter_load_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter
  import mod_counter_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [IdW-1:0]  ptr,
  output logic [IdW-1:0]  grant,
  output logic            valid
);

  int unsigned idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      idx = (32'(ptr) + off) % NREQ;
      if (!valid && req[idx]) begin
        grant = IdW'(idx);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mod_counter_load_ctrl.sv
// Arbitrates NREQ requesters onto the mod-38 counter load port with range check and guard time.
// Optional readback check of dout enabled by defining LOAD_VERIFY_EN.
module mod_counter_load_ctrl #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned W           = mod_counter_pkg::W,
  parameter int unsigned MOD         = mod_counter_pkg::MOD,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0] ack,
  output logic [NREQ-1:0] err,
  output logic            load,
  output logic [W-1:0]    data,
  input  logic [W-1:0]    dout,
  output logic            busy,
  output logic [2:0]      grant_id,
  output logic            verify_err
);

  import mod_counter_pkg::*;

  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HoldInit = (HOLD_CYCLES > 0) ? HW'(HOLD_CYCLES - 1) : '0;
  localparam logic [NREQ-1:0] OneHot0 = NREQ'(1);

  state_e          state_q;
  logic [IdW-1:0]  ptr_q;
  logic [IdW-1:0]  grant_q;
  logic [W-1:0]    data_q;
  logic            load_q;
  logic [NREQ-1:0] ack_q;
  logic [NREQ-1:0] err_q;
  logic [HW-1:0]   hold_q;

  logic [IdW-1:0]  arb_grant;
  logic            arb_valid;
  logic [W-1:0]    sel_data;
  logic            sel_ok;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  assign sel_data = req_data[32'(arb_grant)*W +: W];
  assign sel_ok   = 32'(sel_data) < MOD;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      grant_q <= '0;
      data_q  <= '0;
      load_q  <= 1'b0;
      ack_q   <= '0;
      err_q   <= '0;
      hold_q  <= '0;
    end else begin
      load_q <= 1'b0;
      ack_q  <= '0;
      err_q  <= '0;
      unique case (state_q)
        StIdle: begin
          if (arb_valid) begin
            grant_q <= arb_grant;
            data_q  <= sel_data;
            ptr_q   <= rr_next(arb_grant, NREQ);
            if (sel_ok) begin
              state_q <= StLoad;
              load_q  <= 1'b1;
            end else begin
              err_q <= OneHot0 << arb_grant;
            end
          end
        end
        StLoad: begin
          state_q <= StCheck;
          ack_q   <= OneHot0 << grant_q;
        end
        StCheck: begin
          if (HOLD_CYCLES > 0) begin
            state_q <= StGuard;
            hold_q  <= HoldInit;
          end else begin
            state_q <= StIdle;
          end
        end
        StGuard: begin
          if (hold_q == '0) begin
            state_q <= StIdle;
          end else begin
            hold_q <= hold_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef LOAD_VERIFY_EN
  logic verify_err_q;

  // The counter took the preset at the LOAD->CHECK edge, so dout must equal it during CHECK.
  always_ff @(posedge clk) begin
    if (rst) begin
      verify_err_q <= 1'b0;
    end else if (state_q == StCheck && dout != data_q) begin
      verify_err_q <= 1'b1;
    end
  end

  assign verify_err = verify_err_q;
`else
  logic unused_dout;
  assign unused_dout = ^dout;
  assign verify_err  = 1'b0;
`endif

  assign load     = load_q;
  assign data     = data_q;
  assign ack      = ack_q;
  assign err      = err_q;
  assign grant_id = grant_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_mod_counter_load_ctrl.sv
// Directed bench for mod_counter_load_ctrl: a HOLD_CYCLES=4 instance and a HOLD_CYCLES=0 instance.
module tb_mod_counter_load_ctrl;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 6;
`ifdef LOAD_VERIFY_EN
  localparam logic VerifyOn = 1'b1;
`else
  localparam logic VerifyOn = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*W-1:0] req_data = '0;
  logic [NREQ-1:0] ack, err;
  logic            load, busy, verify_err;
  logic [W-1:0]    data;
  logic [W-1:0]    dout = '0;
  logic [2:0]      grant_id;
  logic            corrupt = 1'b0;

  logic [NREQ-1:0] req0 = '0;
  logic [NREQ*W-1:0] req_data0 = '0;
  logic [NREQ-1:0] ack0, err0;
  logic            load0, busy0, verify_err0;
  logic [W-1:0]    data0;
  logic [W-1:0]    dout0 = '0;
  logic [2:0]      grant_id0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mod_counter_load_ctrl #(.NREQ(NREQ), .W(W), .MOD(38), .HOLD_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .err        (err),
    .load       (load),
    .data       (data),
    .dout       (dout),
    .busy       (busy),
    .grant_id   (grant_id),
    .verify_err (verify_err)
  );

  mod_counter_load_ctrl #(.NREQ(NREQ), .W(W), .MOD(38), .HOLD_CYCLES(0)) dut0 (
    .clk        (clk),
    .rst        (rst),
    .req        (req0),
    .req_data   (req_data0),
    .ack        (ack0),
    .err        (err0),
    .load       (load0),
    .data       (data0),
    .dout       (dout0),
    .busy       (busy0),
    .grant_id   (grant_id0),
    .verify_err (verify_err0)
  );

  // Mod-38 counter models; corrupt makes the first one load preset+1.
  always_ff @(posedge clk) begin
    if (rst) dout <= '0;
    else if (load) dout <= corrupt ? data + 6'd1 : data;
    else dout <= (dout == 6'd37) ? 6'd0 : dout + 6'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) dout0 <= '0;
    else if (load0) dout0 <= data0;
    else dout0 <= (dout0 == 6'd37) ? 6'd0 : dout0 + 6'd1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    check("idle_reached", 32'(busy), 32'd0);
  endtask

  initial begin
    logic seen;
    int   id;

    // Reset state
    tick();
    tick();
    check("rst_load", 32'(load), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_verr", 32'(verify_err), 32'd0);
    rst = 1'b0;

    // Single load from requester 0
    req = 4'b0001;
    req_data[5:0] = 6'd5;
    tick();
    check("t1_load", 32'(load), 32'd1);
    check("t1_data", 32'(data), 32'd5);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_grant", 32'(grant_id), 32'd0);
    tick();
    check("t1_load_off", 32'(load), 32'd0);
    check("t1_ack", 32'(ack), 32'h1);
    check("t1_dout", 32'(dout), 32'd5);
    req = '0;
    tick();
    check("t1_ack_off", 32'(ack), 32'd0);
    check("t1_verr", 32'(verify_err), 32'd0);
    wait_idle();

    // Round robin with all requesters held, from a fresh pointer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1111;
    req_data = {6'd4, 6'd3, 6'd2, 6'd1};
    tick();
    for (int n = 0; n < 5; n++) begin
      id = n % 4;
      check("rr_load", 32'(load), 32'd1);
      check("rr_grant", 32'(grant_id), 32'(id));
      check("rr_data", 32'(data), 32'(id + 1));
      tick();
      check("rr_ack", 32'(ack), 32'd1 << id);
      if (n == 4) req = '0;
      seen = 1'b0;
      repeat (5) begin
        tick();
        seen |= load;
      end
      check("rr_gap_noload", 32'(seen), 32'd0);
      if (n < 4) tick();
    end
    wait_idle();

    // Out-of-range preset rejected, then a legal one accepted
    req = 4'b0100;
    req_data[17:12] = 6'd38;
    tick();
    check("rej_err", 32'(err), 32'h4);
    check("rej_ack", 32'(ack), 32'd0);
    check("rej_load", 32'(load), 32'd0);
    check("rej_busy", 32'(busy), 32'd0);
    check("rej_grant", 32'(grant_id), 32'd2);
    req = '0;
    tick();
    check("rej_err_off", 32'(err), 32'd0);
    check("rej_busy2", 32'(busy), 32'd0);
    req = 4'b0100;
    req_data[17:12] = 6'd37;
    tick();
    check("max_load", 32'(load), 32'd1);
    check("max_data", 32'(data), 32'd37);
    tick();
    check("max_ack", 32'(ack), 32'h4);
    check("max_err", 32'(err), 32'd0);
    req = '0;
    wait_idle();

    // Counter loads the wrong value
    req = 4'b0001;
    req_data[5:0] = 6'd5;
    corrupt = 1'b1;
    tick();
    tick();
    check("bad_dout", 32'(dout), 32'd6);
    check("bad_ack", 32'(ack), 32'h1);
    corrupt = 1'b0;
    req = '0;
    tick();
    check("bad_verr", 32'(verify_err), 32'(VerifyOn));
    wait_idle();
    req = 4'b0001;
    req_data[5:0] = 6'd7;
    tick();
    tick();
    check("good_dout", 32'(dout), 32'd7);
    req = '0;
    tick();
    check("verr_sticky", 32'(verify_err), 32'(VerifyOn));
    wait_idle();

    // Reset during GUARD after a grant to requester 1
    req = 4'b0010;
    req_data[11:6] = 6'd9;
    tick();
    check("g_grant", 32'(grant_id), 32'd1);
    tick();
    check("g_ack", 32'(ack), 32'h2);
    req = '0;
    tick();
    tick();
    check("g_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    check("g_rst_busy", 32'(busy), 32'd0);
    check("g_rst_grant", 32'(grant_id), 32'd0);
    check("g_rst_data", 32'(data), 32'd0);
    check("g_rst_verr", 32'(verify_err), 32'd0);
    check("g_rst_ack", 32'(ack), 32'd0);
    rst = 1'b0;
    req = 4'b0011;
    req_data[5:0] = 6'd3;
    tick();
    check("g_first_load", 32'(load), 32'd1);
    check("g_first_grant", 32'(grant_id), 32'd0);
    tick();
    check("g_first_ack", 32'(ack), 32'h1);
    req = '0;
    wait_idle();

    // HOLD_CYCLES=0 instance: back-to-back every 3 cycles
    req0 = 4'b0011;
    req_data0[5:0]  = 6'd10;
    req_data0[11:6] = 6'd11;
    tick();
    for (int n = 0; n < 4; n++) begin
      id = n % 2;
      check("h0_load", 32'(load0), 32'd1);
      check("h0_grant", 32'(grant_id0), 32'(id));
      check("h0_data", 32'(data0), 32'(10 + id));
      tick();
      check("h0_ack", 32'(ack0), 32'd1 << id);
      check("h0_dout", 32'(dout0), 32'(10 + id));
      tick();
      check("h0_idle", 32'(busy0), 32'd0);
      check("h0_gap", 32'(load0), 32'd0);
      if (n == 3) req0 = '0;
      tick();
    end
    check("h0_done", 32'(busy0), 32'd0);
    check("h0_verr", 32'(verify_err0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
